// File: rtl/ring_arbiter.sv
// ring_arbiter: round-robin arbiter sharing one resource among N requesters.
// A one-hot rotating pointer sets the search start. Each winner is granted
// for one contiguous tenure. The tenure ends on the owner's done, when the
// owner drops req, or when the hold limit is reached.
//
// Ports
//   clock   : rising-edge clock
//   Resetn  : asynchronous active-low reset
//   req     : per-requester request, level, held until served
//   done    : per-requester release pulse (only the owner's bit is used)
//   grant   : registered one-hot grant, zero when idle
//   owner   : binary index of the granted requester, zero when idle
//   busy    : high while any grant is high (registered)
//   timeout : one-cycle pulse after a grant is revoked by the hold limit
module ring_arbiter #(
    parameter int N       = 4,
    parameter int MAXHOLD = 8
) (
    input  logic                 clock,
    input  logic                 Resetn,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout
);
    localparam int OW = $clog2(N);
    localparam int HW = $clog2(MAXHOLD);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;

    // Binary position of the one-hot pointer.
    logic [OW-1:0] ptr_idx;
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q[i]) ptr_idx = OW'(i);
        end
    end

    // Scan upward from the pointer with wrap. The sum needs one extra bit
    // because ptr_idx + offset can reach 2N-2 before the wrap subtraction.
    logic          win_found;
    logic [OW-1:0] win_idx;
    logic [OW:0]   scan;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int off = 0; off < N; off++) begin
            scan = {1'b0, ptr_idx} + (OW+1)'(off);
            if (scan >= (OW+1)'(N)) scan = scan - (OW+1)'(N);
            if (!win_found && req[scan[OW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[OW-1:0];
            end
        end
    end

    logic [N-1:0] win_oh;
    assign win_oh = N'(1) << win_idx;

    logic own_done, own_req, hold_lim;
    assign own_done = done[owner_q];
    assign own_req  = req[owner_q];
    assign hold_lim = (hcnt_q == HW'(MAXHOLD - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        hcnt_d    = hcnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_oh;
                    owner_d = win_idx;
                    hcnt_d  = '0;
                    // The pointer moves just past the winner, so the winner
                    // has lowest priority in the next round.
                    ptr_d   = {win_oh[N-2:0], win_oh[N-1]};
                    state_d = S_GRANT;
                end
            end
            default: begin
                if (own_done || !own_req || hold_lim) begin
                    grant_d   = '0;
                    owner_d   = '0;
                    hcnt_d    = '0;
                    state_d   = S_IDLE;
                    // Flag only releases forced purely by the hold limit.
                    timeout_d = hold_lim && !own_done && own_req;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            ptr_q     <= N'(1);
            grant_q   <= '0;
            owner_q   <= '0;
            hcnt_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            hcnt_q    <= hcnt_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: doc/ring_arbiter.md
# ring_arbiter

Round-robin arbiter that shares one resource between N requesters using a one-hot rotating priority pointer. It is the scheduling counterpart to the team's ring counter: the pointer is a ring of N flops that reset to position 0 and rotate past each winner. The block sits between the requesting datapath units and the shared resource. It issues one registered one-hot grant at a time, with release on `done` and a hold-time limit.

## Interface
- `N`, 4: number of requesters, ≥2.
- `MAXHOLD`, 8: maximum consecutive cycles a single grant may stay high, ≥2.
- `clock` in 1: rising-edge clock, sole clock.
- `Resetn` in 1: reset, asynchronous, active-low.
- `req` in N: request per requester, level-sensitive, held until served.
- `done` in N: release pulse per requester; only the bit of the current owner is honoured.
- `grant` out N: one-hot grant, registered; all-zero when idle.
- `owner` out clog2(N): binary index of the granted requester; 0 when idle.
- `busy` out 1: OR of `grant`.
- `timeout` out 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State: two-state FSM IDLE/GRANT, one-hot pointer `ptr[N-1:0]`, hold counter `hcnt` of width clog2(MAXHOLD).
- Reset (Resetn=0, asynchronous):
  - `grant`=0, `owner`=0, `busy`=0, `timeout`=0.
  - `ptr`=…0001, `hcnt`=0, state IDLE.
  - This takes effect immediately, mid-grant included.
- IDLE:
  - If `req`≠0, select the first asserted `req` bit scanning upward from the `ptr` position, with wrap from N-1 to 0.
  - At the edge: `grant` = that bit, `owner` = its index, `hcnt`=0, `ptr` = that bit rotated left by one (wrapping), state GRANT.
  - If `req`=0, remain in IDLE and hold `ptr`.
- GRANT, evaluated at each edge with owner index k:
  - Release condition: `done[k]`=1, or `req[k]`=0, or `hcnt`=MAXHOLD-1.
  - On release: `grant`=0, `owner`=0, `hcnt`=0, state IDLE.
  - `timeout`=1 for exactly the cycle following a release caused only by the hold limit, i.e. `done[k]`=0 and `req[k]`=1. Otherwise `timeout`=0.
  - If there is no release, `hcnt` increments and `grant` is unchanged.
- Winner selection for the new grant happens only in IDLE, so there is always one idle cycle between consecutive grants.
- `done` bits other than the owner's are ignored in all states. All `done` bits are ignored in IDLE.
- Changes in `req` bits of non-owners during GRANT have no effect until the next IDLE cycle.
- A requester whose grant timed out is re-eligible. Because `ptr` has already moved past it, it wins only if no other requester is asserted.
- Invariant: `grant` is zero or one-hot; `ptr` is always exactly one-hot.

## Timing
- Grant latency: `req` high before edge t while in IDLE, so `grant` is high after edge t. This is 1 cycle.
- Release latency: `done[k]` sampled at edge t, so `grant` is low after edge t. The earliest next grant is after edge t+1.
- Maximum hold: `grant` is high for at most MAXHOLD consecutive cycles. `timeout` is high in the first cycle `grant` is low.
- Simultaneous `done[k]` and other requests at the same edge: release only; the new winner is chosen at the next edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
1. Reset: hold Resetn=0 with `req`=1111. Required: `grant`=0000, `owner`=0, `busy`=0, `timeout`=0. After release with `req`=1111, the first grant is 0001.
2. Rotation: hold `req`=1111 and pulse the owner's `done` 2 cycles after each grant. Required: grants 0001, 0010, 0100, 1000, 0001, each separated by exactly one all-zero cycle.
3. Wrap skip: grant requester 2 (so `ptr`=1000), release it, then apply `req`=0101. Required: next grant 0001, then 0100.
4. Timeout (MAXHOLD=8): hold `req`=0010 with no `done`. Required:
   - `grant`=0010 for exactly 8 cycles, then 0000 with `timeout`=1 for 1 cycle.
   - `grant`=0010 again on the following cycle.
   - Repeat with `req`=0011: after the timeout, 0001 wins.
5. Foreign done: while `grant`=0100, pulse `done`=1011. Required: no change to `grant`, `hcnt` keeps counting, `timeout` stays 0.
6. Reset mid-grant: while `grant`=1000, drive Resetn low between edges. Required: `grant`=0000 and `busy`=0 before the next rising edge. After release with `req`=1000, the grant returns only after one edge, and `ptr` has restarted at 0001.
